tap_ctrl: RTL and testbench

//  IEEE 1149.1 TAP controller FSM; sits directly upstream of the ir/dr shift chains and drives their control strobes.

---
 rtl/jtag_pkg.sv | 31 +++
 rtl/jtag_sync_edge.sv | 37 +++
 rtl/tap_ctrl.sv | 115 +++++++++++
 tb/tb_tap_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Purpose: shared TAP state encoding and small decode helpers for the JTAG block.
// Latency: none (types and pure functions only).
// Backpressure: none.
package jtag_pkg;

    // IEEE 1149.1 state encoding; values are visible on the tap_state port
    typedef enum logic [3:0] {
        TLR      = 4'hF,
        RTI      = 4'hC,
        SEL_DR   = 4'h7,
        CAP_DR   = 4'h6,
        SH_DR    = 4'h2,
        EX1_DR   = 4'h1,
        PAUSE_DR = 4'h3,
        EX2_DR   = 4'h0,
        UPD_DR   = 4'h5,
        SEL_IR   = 4'h4,
        CAP_IR   = 4'hE,
        SH_IR    = 4'hA,
        EX1_IR   = 4'h9,
        PAUSE_IR = 4'hB,
        EX2_IR   = 4'h8,
        UPD_IR   = 4'hD
    } tap_state_t;

    // States in which TDO is actively shifting data out
    function automatic logic is_shift(input tap_state_t s);
        return (s == SH_IR) || (s == SH_DR);
    endfunction

endpackage

// File: rtl/jtag_sync_edge.sv
// Purpose: synchronizes an asynchronous pin into the local clock and flags its edges.
// Latency: pin edge -> o_rise/o_fall pulse after SYNC_STAGES+1 clock edges; pulses are 1 cycle wide.
// Backpressure: none; every synchronized edge produces exactly one pulse.
module jtag_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;
    logic                   r_fall;

    // Synchronizer chain, one delayed copy for edge compare, registered edge pulses
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
            r_fall <= ~r_sync[SYNC_STAGES-1] & r_prev;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/tap_ctrl.sv
// Purpose: IEEE 1149.1 TAP controller; oversamples TCK/TMS in iclk and drives ir/dr strobes.
// Latency: TCK pin edge -> tck_rise/tck_fall and strobes after SYNC_STAGES+1 iclk; state moves one iclk later.
// Backpressure: none; TCK high/low must each last at least SYNC_STAGES+2 iclk periods.
module tap_ctrl
    import jtag_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       iclk,
    input  logic       reset,
    input  logic       tck,
    input  logic       tms,
    output logic [3:0] tap_state,
    output logic       tlr,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       clk_ir,
    output logic       update_ir,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       clk_dr,
    output logic       update_dr,
    output logic       tdo_oe,
    output logic       tck_rise,
    output logic       tck_fall
);

    logic               w_tck_rise;
    logic               w_tck_fall;
    logic               w_tms;
    logic               w_pulse_en;
    logic [SYNC_STAGES:0] r_tms_sync;
    tap_state_t         r_state;
    tap_state_t         w_next;
    logic               r_tdo_oe;

    jtag_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_tck_sync (
        .i_clk   (iclk),
        .i_reset (reset),
        .i_sig   (tck),
        .o_rise  (w_tck_rise),
        .o_fall  (w_tck_fall)
    );

    // TMS gets one flop more than the synchronizer so it lines up with the registered tck edge
    always_ff @(posedge iclk) begin
        if (reset) begin
            r_tms_sync <= '0;
        end else begin
            r_tms_sync <= {r_tms_sync[SYNC_STAGES-1:0], tms};
        end
    end

    assign w_tms = r_tms_sync[SYNC_STAGES];

    // Standard 1149.1 next-state function; the IR column mirrors the DR column
    always_comb begin
        w_next = r_state;
        case (r_state)
            TLR:      w_next = w_tms ? TLR      : RTI;
            RTI:      w_next = w_tms ? SEL_DR   : RTI;
            SEL_DR:   w_next = w_tms ? SEL_IR   : CAP_DR;
            CAP_DR:   w_next = w_tms ? EX1_DR   : SH_DR;
            SH_DR:    w_next = w_tms ? EX1_DR   : SH_DR;
            EX1_DR:   w_next = w_tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: w_next = w_tms ? EX2_DR   : PAUSE_DR;
            EX2_DR:   w_next = w_tms ? UPD_DR   : SH_DR;
            UPD_DR:   w_next = w_tms ? SEL_DR   : RTI;
            SEL_IR:   w_next = w_tms ? TLR      : CAP_IR;
            CAP_IR:   w_next = w_tms ? EX1_IR   : SH_IR;
            SH_IR:    w_next = w_tms ? EX1_IR   : SH_IR;
            EX1_IR:   w_next = w_tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: w_next = w_tms ? EX2_IR   : PAUSE_IR;
            EX2_IR:   w_next = w_tms ? UPD_IR   : SH_IR;
            UPD_IR:   w_next = w_tms ? SEL_DR   : RTI;
            default:  w_next = TLR;
        endcase
    end

    // State advances on tck rise; TDO enable follows the state at tck fall
    always_ff @(posedge iclk) begin
        if (reset) begin
            r_state  <= TLR;
            r_tdo_oe <= 1'b0;
        end else begin
            if (w_tck_rise) begin
                r_state <= w_next;
            end
            if (w_tck_fall) begin
                r_tdo_oe <= is_shift(r_state);
            end
        end
    end

    // A reset raised in a pulse cycle must also kill that cycle's strobes
    assign w_pulse_en = ~reset;

    // Strobes decode the state being left, so the chains shift with the pre-transition state
    assign tap_state  = r_state;
    assign tlr        = (r_state == TLR);
    assign capture_ir = (r_state == CAP_IR);
    assign shift_ir   = (r_state == SH_IR);
    assign capture_dr = (r_state == CAP_DR);
    assign shift_dr   = (r_state == SH_DR);
    assign clk_ir     = w_pulse_en & w_tck_rise & ((r_state == CAP_IR) || (r_state == SH_IR));
    assign clk_dr     = w_pulse_en & w_tck_rise & ((r_state == CAP_DR) || (r_state == SH_DR));
    assign update_ir  = w_pulse_en & w_tck_fall & (r_state == UPD_IR);
    assign update_dr  = w_pulse_en & w_tck_fall & (r_state == UPD_DR);
    assign tck_rise   = w_pulse_en & w_tck_rise;
    assign tck_fall   = w_pulse_en & w_tck_fall;
    assign tdo_oe     = r_tdo_oe;

endmodule

// File: tb/tb_tap_ctrl.sv
// Purpose: self-checking bench for tap_ctrl against a pin-history reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_tap_ctrl;

    // Bench-owned copy of the IEEE state encoding
    localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SELDR = 4'h7, S_CAPDR = 4'h6;
    localparam logic [3:0] S_SHDR = 4'h2, S_EX1DR = 4'h1, S_PAUSEDR = 4'h3, S_EX2DR = 4'h0;
    localparam logic [3:0] S_UPDDR = 4'h5, S_SELIR = 4'h4, S_CAPIR = 4'hE, S_SHIR = 4'hA;
    localparam logic [3:0] S_EX1IR = 4'h9, S_PAUSEIR = 4'hB, S_EX2IR = 4'h8, S_UPDIR = 4'hD;

    logic       iclk = 1'b0;
    logic       reset, tck, tms;
    logic [3:0] tap_state;
    logic       tlr, capture_ir, shift_ir, clk_ir, update_ir;
    logic       capture_dr, shift_dr, clk_dr, update_dr;
    logic       tdo_oe, tck_rise, tck_fall;

    tap_ctrl #(.SYNC_STAGES(2)) dut (
        .iclk       (iclk),
        .reset      (reset),
        .tck        (tck),
        .tms        (tms),
        .tap_state  (tap_state),
        .tlr        (tlr),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .clk_ir     (clk_ir),
        .update_ir  (update_ir),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .clk_dr     (clk_dr),
        .update_dr  (update_dr),
        .tdo_oe     (tdo_oe),
        .tck_rise   (tck_rise),
        .tck_fall   (tck_fall)
    );

    always #5 iclk = ~iclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // TAP transition table: nxt1 for TMS=1, nxt0 for TMS=0
    logic [3:0] nxt1 [16];
    logic [3:0] nxt0 [16];

    task automatic arc(input logic [3:0] s, input logic [3:0] on1, input logic [3:0] on0);
        nxt1[s] = on1;
        nxt0[s] = on0;
    endtask

    initial begin
        arc(S_TLR,     S_TLR,     S_RTI);
        arc(S_RTI,     S_SELDR,   S_RTI);
        arc(S_SELDR,   S_SELIR,   S_CAPDR);
        arc(S_CAPDR,   S_EX1DR,   S_SHDR);
        arc(S_SHDR,    S_EX1DR,   S_SHDR);
        arc(S_EX1DR,   S_UPDDR,   S_PAUSEDR);
        arc(S_PAUSEDR, S_EX2DR,   S_PAUSEDR);
        arc(S_EX2DR,   S_UPDDR,   S_SHDR);
        arc(S_UPDDR,   S_SELDR,   S_RTI);
        arc(S_SELIR,   S_TLR,     S_CAPIR);
        arc(S_CAPIR,   S_EX1IR,   S_SHIR);
        arc(S_SHIR,    S_EX1IR,   S_SHIR);
        arc(S_EX1IR,   S_UPDIR,   S_PAUSEIR);
        arc(S_PAUSEIR, S_EX2IR,   S_PAUSEIR);
        arc(S_EX2IR,   S_UPDIR,   S_SHIR);
        arc(S_UPDIR,   S_SELDR,   S_RTI);
    end

    // Reference model: pin history seen by iclk, edges appear 2 samples late
    logic [3:0] m_state;
    bit         m_rise, m_fall, m_tms, m_tdo, sb_en = 1'b0;
    bit   [3:0] h, th;
    logic [11:0] exp_v, got_v;
    bit         g;
    int n_clk_ir, n_sh_ir, n_clk_dr, n_upd_ir, n_upd_dr, n_rise;

    always begin
        @(posedge iclk);
        if (reset) begin
            m_state = S_TLR;
            m_rise = 1'b0; m_fall = 1'b0; m_tms = 1'b0; m_tdo = 1'b0;
            h = '0; th = '0;
            sb_en = 1'b1;
        end else begin
            if (m_rise) m_state = m_tms ? nxt1[m_state] : nxt0[m_state];
            if (m_fall) m_tdo = (m_state == S_SHIR) || (m_state == S_SHDR);
            h  = {h[2:0], tck};
            th = {th[2:0], tms};
            m_rise = h[2] & ~h[3];
            m_fall = ~h[2] & h[3];
            m_tms  = th[2];
        end
        #1;
        if (sb_en) begin
            g = ~reset;
            exp_v = {m_state == S_TLR, m_state == S_CAPIR, m_state == S_SHIR,
                     g & m_rise & ((m_state == S_CAPIR) || (m_state == S_SHIR)),
                     g & m_fall & (m_state == S_UPDIR),
                     m_state == S_CAPDR, m_state == S_SHDR,
                     g & m_rise & ((m_state == S_CAPDR) || (m_state == S_SHDR)),
                     g & m_fall & (m_state == S_UPDDR),
                     m_tdo, g & m_rise, g & m_fall};
            got_v = {tlr, capture_ir, shift_ir, clk_ir, update_ir, capture_dr, shift_dr,
                     clk_dr, update_dr, tdo_oe, tck_rise, tck_fall};
            check("sb_state", 32'(tap_state), 32'(m_state));
            check("sb_outs", 32'(got_v), 32'(exp_v));
            if (clk_ir) n_clk_ir++;
            if (clk_ir && shift_ir) n_sh_ir++;
            if (clk_dr) n_clk_dr++;
            if (update_ir) n_upd_ir++;
            if (update_dr) n_upd_dr++;
            if (tck_rise) n_rise++;
        end
    end

    task automatic clr();
        n_clk_ir = 0; n_sh_ir = 0; n_clk_dr = 0; n_upd_ir = 0; n_upd_dr = 0; n_rise = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge iclk);
    endtask

    // One TCK period of 8 iclk: 4 low (TMS set at start), 4 high
    task automatic tck_cycle(input logic v);
        @(negedge iclk);
        tms = v;
        repeat (3) @(negedge iclk);
        tck = 1'b1;
        repeat (4) @(negedge iclk);
        tck = 1'b0;
    endtask

    // Sends n TMS bits, bit 0 first
    task automatic send(input logic [31:0] bits, input int n);
        logic [31:0] b;
        b = bits;
        for (int i = 0; i < n; i++) tck_cycle(b[i]);
    endtask

    initial begin
        clr();
        reset = 1'b1; tck = 1'b0; tms = 1'b0;
        repeat (2) @(posedge iclk);
        @(negedge iclk);
        check("rst_state", 32'(tap_state), 32'hF);
        check("rst_tlr", 32'(tlr), 32'd1);
        check("rst_levels", 32'({capture_ir, shift_ir, capture_dr, shift_dr, tdo_oe}), 32'd0);
        check("rst_pulses", 32'({clk_ir, update_ir, clk_dr, update_dr, tck_rise, tck_fall}), 32'd0);
        reset = 1'b0;

        // IR scan: TLR -> SH_IR, 8 shifts, exit through UPD_IR
        clr();
        send(32'b00110, 5);
        check("ir_enter", 32'(tap_state), 32'(S_SHIR));
        send(32'h80, 8);
        send(32'b11, 2);
        idle(6);
        check("ir_clk_cnt", 32'(n_clk_ir), 32'd9);
        check("ir_shift_cnt", 32'(n_sh_ir), 32'd8);
        check("ir_upd_cnt", 32'(n_upd_ir), 32'd1);
        check("ir_end", 32'(tap_state), 32'(S_SELDR));

        // DR scan: back to TLR, then TLR -> SH_DR, watch tdo_oe timing
        send(32'b11, 2);
        check("to_tlr", 32'(tap_state), 32'(S_TLR));
        clr();
        send(32'b0010, 4);
        check("dr_enter", 32'(tap_state), 32'(S_SHDR));
        check("dr_oe_before", 32'(tdo_oe), 32'd0);
        idle(5);
        check("dr_oe_on", 32'(tdo_oe), 32'd1);
        send(32'b1000, 4);
        check("dr_ex1", 32'(tap_state), 32'(S_EX1DR));
        check("dr_oe_hold", 32'(tdo_oe), 32'd1);
        idle(5);
        check("dr_oe_off", 32'(tdo_oe), 32'd0);
        check("dr_clk_cnt", 32'(n_clk_dr), 32'd5);
        send(32'b0, 1);
        check("dr_pause", 32'(tap_state), 32'(S_PAUSEDR));

        // Five TMS=1 from PAUSE_DR reach TLR exactly on the fifth rise
        clr();
        send(32'b1111, 4);
        check("p5_fourth", 32'(tap_state), 32'(S_SELIR));
        send(32'b1, 1);
        check("p5_tlr", 32'(tap_state), 32'(S_TLR));
        check("p5_tlr_lvl", 32'(tlr), 32'd1);
        idle(6);
        check("p5_upd_dr", 32'(n_upd_dr), 32'd1);
        check("p5_upd_ir", 32'(n_upd_ir), 32'd0);

        // Reset lands on the edge that would launch a SH_IR tck_rise
        send(32'b00110, 5);
        idle(6);
        check("r5_oe_pre", 32'(tdo_oe), 32'd1);
        clr();
        @(negedge iclk);
        tms = 1'b0;
        repeat (3) @(negedge iclk);
        tck = 1'b1;
        @(negedge iclk);
        @(negedge iclk);
        reset = 1'b1;
        @(negedge iclk);
        check("r5_state", 32'(tap_state), 32'(S_TLR));
        check("r5_oe", 32'(tdo_oe), 32'd0);
        check("r5_clk_ir", 32'(n_clk_ir), 32'd0);
        // Release reset with TCK already high: one spurious rise, TMS=1 keeps TLR
        tms = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(8);
        check("spur_rise", 32'(n_rise), 32'd1);
        check("spur_state", 32'(tap_state), 32'(S_TLR));
        tck = 1'b0;
        idle(6);

        // Random TMS traffic, checked cycle by cycle by the model
        for (int i = 0; i < 1000; i++) begin
            tck_cycle($urandom_range(0, 99) < 35);
        end
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
